// File: rtl/sub_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : sub_cmd_issuer
// Purpose  : Issues ARM -> gap -> FIRE on a sub-style target's func bus and
//            reports done/error. Optional retry: define SUB_CMD_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sub_cmd_issuer #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 8,
  parameter int MAX_RETRY  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       target_out_i,
  output logic [1:0] func_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam logic [2:0] C_IDLE = 3'd0;
  localparam logic [2:0] C_ARM  = 3'd1;
  localparam logic [2:0] C_GAP  = 3'd2;
  localparam logic [2:0] C_FIRE = 3'd3;
  localparam logic [2:0] C_WAIT = 3'd4;
  localparam logic [2:0] C_DONE = 3'd5;
  localparam logic [2:0] C_ERR  = 3'd6;

  localparam logic [7:0] C_GAP_LOAD = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);

  logic [2:0] state_q, state_d;
  logic       armed_q, armed_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] w_cnt_inc;

  assign w_cnt_inc = cnt_q + 8'd1;

`ifdef SUB_CMD_RETRY_EN
  localparam logic [7:0] C_MAX_RETRY = 8'(MAX_RETRY);
  logic [7:0] retry_q, retry_d;
`else
  logic [7:0] w_unused_max_retry;
  assign w_unused_max_retry = 8'(MAX_RETRY);
`endif

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
`ifdef SUB_CMD_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      C_IDLE: begin
        if (req_valid_i && req_ready_o) begin
          // An already-armed target only needs the FIRE command
          state_d = armed_q ? C_FIRE : C_ARM;
`ifdef SUB_CMD_RETRY_EN
          retry_d = 8'd0;
`endif
        end
      end
      C_ARM: begin
        armed_d = 1'b1;
        if (GAP_CYCLES > 0) begin
          state_d = C_GAP;
          cnt_d   = C_GAP_LOAD;
        end else begin
          state_d = C_FIRE;
        end
      end
      C_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = C_FIRE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      C_FIRE: begin
        cnt_d   = 8'd0;
        state_d = C_WAIT;
      end
      C_WAIT: begin
        if (target_out_i) begin
          state_d = C_DONE;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == C_TIMEOUT) begin
`ifdef SUB_CMD_RETRY_EN
            if (retry_q < C_MAX_RETRY) begin
              retry_d = retry_q + 8'd1;
              armed_d = 1'b0;
              state_d = C_ARM;
            end else begin
              state_d = C_ERR;
            end
`else
            state_d = C_ERR;
`endif
          end
        end
      end
      C_DONE: state_d = C_IDLE;
      C_ERR: begin
        armed_d = 1'b0;
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= C_IDLE;
      armed_q <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef SUB_CMD_RETRY_EN
      retry_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
`ifdef SUB_CMD_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  // Ready is gated by reset so nothing can be accepted while rst_ni is low
  assign req_ready_o = (state_q == C_IDLE) && rst_ni;
  assign func_o      = (state_q == C_ARM)  ? 2'd1 :
                       (state_q == C_FIRE) ? 2'd2 : 2'd0;
  assign busy_o      = (state_q != C_IDLE);
  assign done_o      = (state_q == C_DONE);
  assign error_o     = (state_q == C_ERR);

endmodule
`default_nettype wire

// File: tb/tb_sub_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_cmd_issuer
// Purpose  : Directed self-checking bench for sub_cmd_issuer with a simple
//            sticky-enable / sticky-out target model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       tgt_out, tgt_en;
  logic [1:0] func;
  logic       busy, done, error;
  logic       stub = 1'b0;
  logic       tgt_clr = 1'b0;
  logic       tgt_clr_out = 1'b0;

  logic       req_valid0 = 1'b0;
  logic       req_ready0, tgt_out0, tgt_en0, busy0, done0, error0;
  logic [1:0] func0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_cmd_issuer #(.GAP_CYCLES(2), .TIMEOUT(8), .MAX_RETRY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .target_out_i(tgt_out), .func_o(func), .busy_o(busy), .done_o(done), .error_o(error)
  );

  sub_cmd_issuer #(.GAP_CYCLES(0), .TIMEOUT(8), .MAX_RETRY(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .target_out_i(tgt_out0), .func_o(func0), .busy_o(busy0), .done_o(done0), .error_o(error0)
  );

  // Target: ARM sets sticky enable, FIRE sets sticky out when enabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || tgt_clr) begin
      tgt_en <= 1'b0; tgt_out <= 1'b0;
    end else begin
      if (func == 2'd1) tgt_en <= 1'b1;
      if (tgt_clr_out) tgt_out <= 1'b0;
      else if (func == 2'd2 && tgt_en && !stub) tgt_out <= 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_en0 <= 1'b0; tgt_out0 <= 1'b0;
    end else begin
      if (func0 == 2'd1) tgt_en0 <= 1'b1;
      if (func0 == 2'd2 && tgt_en0) tgt_out0 <= 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (req_ready !== 1'b0 || func !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: ready=%b func=%0d busy=%b done=%b error=%b, required all 0",
                 req_ready, func, busy, done, error);
      end
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
  endtask

  task automatic test_cold();
    logic [1:0] ef [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    tick();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL cold_ready0: got %b, required 1", req_ready);
    end
    req_valid = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      n_cmp++;
      if (func !== ef[c]) begin
        n_bad++; $display("FAIL cold_func c%0d: got %0d, required %0d", c, func, ef[c]);
      end
      n_cmp++;
      if (done !== (c == 6) || error !== 1'b0) begin
        n_bad++; $display("FAIL cold_done c%0d: done=%b error=%b, required done=%b error=0", c, done, error, c == 6);
      end
      n_cmp++;
      if (req_ready !== (c == 7)) begin
        n_bad++; $display("FAIL cold_ready c%0d: got %b, required %b", c, req_ready, c == 7);
      end
    end
    n_cmp++;
    if (tgt_out !== 1'b1) begin
      n_bad++; $display("FAIL cold_target: out=%b, required 1", tgt_out);
    end
  endtask

  task automatic test_warm();
    logic [1:0] ef [5] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    tgt_clr_out = 1'b1;
    tick();
    tgt_clr_out = 1'b0;
    req_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      n_cmp++;
      if (func !== ef[c]) begin
        n_bad++; $display("FAIL warm_func c%0d: got %0d, required %0d", c, func, ef[c]);
      end
      n_cmp++;
      if (done !== (c == 3) || error !== 1'b0) begin
        n_bad++; $display("FAIL warm_done c%0d: done=%b error=%b, required done=%b error=0", c, done, error, c == 3);
      end
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL warm_ready: got %b, required 1", req_ready);
    end
  endtask

`ifndef SUB_CMD_RETRY_EN
  task automatic test_timeout();
    bit got;
    stub = 1'b1;
    tgt_clr_out = 1'b1;
    tick();
    tgt_clr_out = 1'b0;
    req_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      n_cmp++;
      if (func !== ((c == 1) ? 2'd2 : 2'd0)) begin
        n_bad++; $display("FAIL tmo_func c%0d: got %0d, required %0d", c, func, (c == 1) ? 2 : 0);
      end
      n_cmp++;
      if (error !== (c == 10) || done !== 1'b0) begin
        n_bad++; $display("FAIL tmo_error c%0d: error=%b done=%b, required error=%b done=0", c, error, done, c == 10);
      end
      n_cmp++;
      if (busy !== (c <= 10)) begin
        n_bad++; $display("FAIL tmo_busy c%0d: got %b, required %b", c, busy, c <= 10);
      end
    end
    stub = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (func !== 2'd1) begin
      n_bad++; $display("FAIL tmo_rearm: func=%0d, required 1", func);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL tmo_recover: done seen=%b, required 1", got);
    end
    tick();
  endtask
`else
  task automatic test_retry();
    int n_fire, n_arm, n_err, n_done;
    stub = 1'b1;
    tgt_clr_out = 1'b1;
    tick();
    tgt_clr_out = 1'b0;
    n_fire = 0; n_arm = 0; n_err = 0; n_done = 0;
    req_valid = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (func == 2'd2) n_fire++;
      if (func == 2'd1) n_arm++;
      if (error) n_err++;
      if (done) n_done++;
    end
    n_cmp++;
    if (n_fire !== 3 || n_err !== 1 || n_done !== 0 || n_arm !== 2) begin
      n_bad++; $display("FAIL retry_exhaust: fires=%0d arms=%0d errors=%0d dones=%0d, required 3/2/1/0",
                        n_fire, n_arm, n_err, n_done);
    end
    n_fire = 0; n_err = 0; n_done = 0;
    req_valid = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) req_valid = 1'b0;
      if (func == 2'd2) n_fire++;
      if (func == 2'd1 && n_fire == 1) stub = 1'b0;
      if (error) n_err++;
      if (done) n_done++;
    end
    n_cmp++;
    if (n_fire !== 2 || n_err !== 0 || n_done !== 1) begin
      n_bad++; $display("FAIL retry_release: fires=%0d errors=%0d dones=%0d, required 2/0/1",
                        n_fire, n_err, n_done);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit got;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (func !== 2'd1) begin
      n_bad++; $display("FAIL rstmid_arm: func=%0d, required 1", func);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b1 || func !== 2'd0) begin
      n_bad++; $display("FAIL rstmid_gap: busy=%b func=%0d, required 1/0", busy, func);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || func !== 2'd0 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: busy=%b func=%0d ready=%b, required 0/0/0", busy, func, req_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (done !== 1'b0 || error !== 1'b0) begin
        n_bad++; $display("FAIL rstmid_pulse: done=%b error=%b, required 0/0", done, error);
      end
    end
    rst_n = 1'b1;
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if (func !== 2'd1) begin
      n_bad++; $display("FAIL rstmid_rearm: func=%0d, required 1", func);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL rstmid_done: done seen=%b, required 1", got);
    end
    tick();
  endtask

  task automatic test_gap0();
    logic [1:0] ef [10] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
    n_cmp++;
    if (req_ready0 !== 1'b1 || busy0 !== 1'b0) begin
      n_bad++; $display("FAIL gap0_idle: ready=%b busy=%b, required 1/0", req_ready0, busy0);
    end
    req_valid0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_cmp++;
      if (func0 !== ef[c]) begin
        n_bad++; $display("FAIL gap0_func c%0d: got %0d, required %0d", c, func0, ef[c]);
      end
      n_cmp++;
      if (req_ready0 !== (c == 5 || c == 9)) begin
        n_bad++; $display("FAIL gap0_ready c%0d: got %b, required %b", c, req_ready0, c == 5 || c == 9);
      end
      n_cmp++;
      if (done0 !== (c == 4 || c == 8) || error0 !== 1'b0) begin
        n_bad++; $display("FAIL gap0_done c%0d: done=%b error=%b, required done=%b error=0",
                          c, done0, error0, c == 4 || c == 8);
      end
    end
    req_valid0 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold();
    test_warm();
`ifdef SUB_CMD_RETRY_EN
    test_retry();
`else
    test_timeout();
`endif
    test_reset_mid();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sub_cmd_issuer.md
Name: sub_cmd_issuer

Overview:
Command initiator that drives the 2-bit func bus of a sub-style target: ARM (func=1) sets the target's sticky enable; FIRE (func=2) sets its sticky out only when enabled. The block accepts requests on a valid/ready handshake and sequences ARM -> gap -> FIRE. It then watches the target's out for completion and reports done or error. It sits between the control sequencer and one target instance.

Parameters:
GAP_CYCLES, 2, idle (func=0) cycles between ARM and FIRE; 0 means FIRE directly follows ARM
TIMEOUT, 8, maximum WAIT cycles for target_out before error; legal range 1..255
MAX_RETRY, 2, re-attempts after timeout; used only with SUB_CMD_RETRY_EN

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request to run one ARM/FIRE sequence
req_ready  output  1  high only in IDLE with rst deasserted
target_out  input  1  target's out register, fed back
func  output  2  command to target: 0 NOP, 1 ARM, 2 FIRE; 3 is never driven
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse on timeout (final attempt)

Behaviour:
- Reset (rst low, async): state=IDLE, armed=0, wait counter=0, retry count=0. func=0, done=0, error=0, busy=0, req_ready=0 while rst is low.
- States: IDLE, ARM, GAP, FIRE, WAIT, DONE, ERR. Outputs are Moore decodes of the state register. func=1 only in ARM and func=2 only in FIRE; func=0 in all other states.
- IDLE: accept when req_valid && req_ready. On accept, go to ARM if armed=0, else go to FIRE (armed skips ARM and GAP).
- ARM: lasts 1 cycle. Sets armed=1. Next state is GAP if GAP_CYCLES>0, else FIRE.
- GAP: exactly GAP_CYCLES cycles, counted down, then FIRE.
- FIRE: lasts 1 cycle. Clears the wait counter. Next state is WAIT.
- WAIT: if target_out=1, go to DONE. If target_out=0, increment the counter; when the counter reaches TIMEOUT, go to ERR. target_out is sampled in the first WAIT cycle, because the target registers out one cycle after FIRE.
- DONE: done=1 for 1 cycle, then IDLE.
- ERR: error=1 for 1 cycle. Clears armed so the next request re-arms. Then IDLE.
- target_out already 1 at accept: the full sequence is still issued, and completion occurs in the first WAIT cycle.
- req_valid is ignored outside IDLE. No queuing, no back-to-back accept: there is at least one IDLE cycle between requests.
- done and error are never high in the same cycle.
- Reset asserted mid-sequence: func drops to 0 asynchronously, no done/error pulse, and armed is cleared.
- Counters are sized for 8 bits; TIMEOUT is not allowed to wrap.

Optional Feature:
SUB_CMD_RETRY_EN
- Defined: on timeout in WAIT, if the retry count < MAX_RETRY, increment it, clear armed, and go to ARM with no error pulse. If the retry count equals MAX_RETRY, go to ERR. The retry count is cleared on every accept.
- Undefined: the first timeout goes straight to ERR. No retry counter logic is present, and MAX_RETRY is ignored.

Test Plan:
- Reset, cold request, target model responds: rst low for 3 cycles, then req_valid at cycle 0 -> func=1 at cycle 1, func=0 at cycles 2-3, func=2 at cycle 4, target_out=1 at cycle 5, done=1 at cycle 6, req_ready=1 at cycle 7; error stays 0.
- Warm request (armed=1) -> func=2 at cycle 1, done at cycle 3, and no ARM cycle appears.
- Target held with out=0 (stubbed), TIMEOUT=8, retry feature off -> 8 WAIT cycles, error=1 at the 9th cycle after FIRE. Next request issues ARM again.
- With SUB_CMD_RETRY_EN and MAX_RETRY=2, target stubbed with out=0 -> three ARM/FIRE sequences, then exactly one error pulse. If target_out is released on the 2nd attempt, done pulses and error stays 0.
- rst pulsed low during GAP -> func=0 and busy=0 immediately, no done/error pulse; after release, the next request starts with ARM.
- GAP_CYCLES=0 and req_valid held high continuously -> ARM is directly followed by FIRE; one accept per sequence; req_ready is low for the whole sequence; func never equals 3.
